// File: rtl/ldpc_pkg.sv
// Definitions shared by the LDPC encoder datapath: codeword geometry and the
// layout of an output-buffer FIFO entry.
package ldpc_pkg;

  localparam int unsigned CW_BITS  = 1024;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CW_BYTES = CW_BITS / BYTE_W;

  // FIFO entry is {eof, sof, byte}
  localparam int unsigned SOF_BIT  = 8;
  localparam int unsigned EOF_BIT  = 9;
  localparam int unsigned ENTRY_W  = EOF_BIT + 1;

endpackage

// File: rtl/codeword_out_buf_if.sv
// Valid/ready byte stream leaving the codeword output buffer, tagged with
// start/end-of-codeword markers.
interface codeword_out_buf_if;

  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eof;
  logic       m_vld;
  logic       m_rdy;

  modport master (
    output m_data,
    output m_sof,
    output m_eof,
    output m_vld,
    input  m_rdy
  );

  modport slave (
    input  m_data,
    input  m_sof,
    input  m_eof,
    input  m_vld,
    output m_rdy
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with async reset and sync clear; reports the
// accepted write/read strobes and the next-state occupancy to its owner.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             wr_acc_o,
  output logic             rd_acc_o,
  output logic [AW:0]      count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign rd_acc = rd_en_i & ~empty;
  assign wr_acc = wr_en_i & (~full | rd_acc);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_acc) wptr_d = wptr_q + (AW)'(1);
    if (rd_acc) rptr_d = rptr_q + (AW)'(1);
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (!clr_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o    = mem_q[rptr_q];
  assign empty_o      = empty;
  assign wr_acc_o     = wr_acc;
  assign rd_acc_o     = rd_acc;
  assign count_next_o = cnt_d;

endmodule

// File: rtl/codeword_out_buf.sv
// Buffers LDPC encoder output bytes, tags codeword boundaries, and streams them
// downstream with almost-full back-pressure, overflow flag and codeword count.
module codeword_out_buf
  import ldpc_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rst_c,
  input  logic [7:0]                cw_byte,
  input  logic                      cw_vld,
  output logic                      cw_afull,
  codeword_out_buf_if.master        m,
  output logic [15:0]               frame_cnt,
  output logic                      ovf_err
);

  logic [6:0]         idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        frame_q, frame_d;
  logic               afull_q, afull_d;

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               empty;
  logic               wr_acc;
  logic               rd_acc;
  logic [AW:0]        cnt_next;
  logic               idx_last;

  assign idx_last = (idx_q == 7'(CW_BYTES - 1));

  always_comb begin
    wr_entry               = '0;
    wr_entry[BYTE_W-1:0]   = cw_byte;
    wr_entry[SOF_BIT]      = (idx_q == '0);
    wr_entry[EOF_BIT]      = idx_last;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_n_i      (rst_c),
    .wr_en_i      (cw_vld),
    .wr_data_i    (wr_entry),
    .rd_en_i      (m.m_rdy),
    .rd_data_o    (head),
    .empty_o      (empty),
    .wr_acc_o     (wr_acc),
    .rd_acc_o     (rd_acc),
    .count_next_o (cnt_next)
  );

  always_comb begin
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    frame_d = frame_q;
    // Index follows encoder timing even for dropped bytes to keep framing aligned.
    if (cw_vld) idx_d = idx_last ? '0 : idx_q + 7'd1;
    if (cw_vld && !wr_acc) ovf_d = 1'b1;
    if (rd_acc && head[EOF_BIT]) frame_d = frame_q + 16'd1;
    afull_d = (cnt_next >= (AW+1)'(DEPTH - AF_MARGIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
      afull_q <= 1'b0;
    end else if (!rst_c) begin
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
      afull_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
      afull_q <= afull_d;
    end
  end

  // Stale RAM contents are masked so the outputs read zero whenever nothing is valid.
  assign m.m_vld  = ~empty;
  assign m.m_data = empty ? '0   : head[BYTE_W-1:0];
  assign m.m_sof  = empty ? 1'b0 : head[SOF_BIT];
  assign m.m_eof  = empty ? 1'b0 : head[EOF_BIT];

  assign cw_afull  = afull_q;
  assign frame_cnt = frame_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_codeword_out_buf.sv
// Directed bench for codeword_out_buf: reset/clear, framing, overflow,
// full-with-pop, stalled output and mid-codeword clear.
module tb_codeword_out_buf;

  logic        clk;
  logic        rst_n;
  logic        rst_c;
  logic [7:0]  cw_byte;
  logic        cw_vld;
  logic        cw_afull;
  logic [15:0] frame_cnt;
  logic        ovf_err;

  codeword_out_buf_if bus ();

  codeword_out_buf #(
    .DEPTH     (16),
    .AW        (4),
    .AF_MARGIN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_c     (rst_c),
    .cw_byte   (cw_byte),
    .cw_vld    (cw_vld),
    .cw_afull  (cw_afull),
    .m         (bus),
    .frame_cnt (frame_cnt),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          bad;
  logic [9:0]  q [$];
  int          midx;
  logic        mov;
  logic [15:0] mframes;
  int          npop;
  int          nsof;
  int          neof;
  logic [7:0]  last_data;
  logic        sof_80;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    midx    = 0;
    mov     = 1'b0;
    mframes = '0;
  endtask

  // One clock: drive inputs, check outputs against the model, update model, advance.
  task automatic cyc(input logic vld, input logic [7:0] b, input logic rdy);
    logic       pop;
    logic       full;
    logic [9:0] e;
    cw_vld    = vld;
    cw_byte   = b;
    bus.m_rdy = rdy;
    chk("m_vld", 32'(bus.m_vld), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      chk("m_data", 32'(bus.m_data), 32'(e[7:0]));
      chk("m_sof",  32'(bus.m_sof),  32'(e[8]));
      chk("m_eof",  32'(bus.m_eof),  32'(e[9]));
    end
    chk("cw_afull",  32'(cw_afull),  32'(q.size() >= 12));
    chk("ovf_err",   32'(ovf_err),   32'(mov));
    chk("frame_cnt", 32'(frame_cnt), 32'(mframes));
    if (bus.m_vld && rdy) begin
      npop++;
      last_data = bus.m_data;
      if (bus.m_sof) nsof++;
      if (bus.m_eof) neof++;
      if (bus.m_data == 8'h80) sof_80 = bus.m_sof;
    end
    pop  = rdy && (q.size() != 0);
    full = (q.size() == 16);
    if (pop) begin
      e = q.pop_front();
      if (e[9]) mframes = mframes + 16'd1;
    end
    if (vld) begin
      e = {(midx == 127), (midx == 0), b};
      if (!full || pop) q.push_back(e);
      else mov = 1'b1;
      midx = (midx + 1) % 128;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q.size() != 0; k++) cyc(1'b0, 8'h00, 1'b1);
    chk("drained", 32'(bus.m_vld), 32'd0);
  endtask

  task automatic do_clear();
    rst_c     = 1'b0;
    cw_vld    = 1'b0;
    bus.m_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst_c = 1'b1;
    model_reset();
    chk("clr_vld", 32'(bus.m_vld), 32'd0);
    chk("clr_frame", 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    int  sent;
    logic v;
    total     = 0;
    bad       = 0;
    npop      = 0;
    nsof      = 0;
    neof      = 0;
    last_data = '0;
    sof_80    = 1'b0;
    rst_n     = 1'b0;
    rst_c     = 1'b1;
    cw_vld    = 1'b0;
    cw_byte   = '0;
    bus.m_rdy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: async reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_vld",   32'(bus.m_vld),  32'd0);
    chk("rst_data",  32'(bus.m_data), 32'd0);
    chk("rst_sof",   32'(bus.m_sof),  32'd0);
    chk("rst_eof",   32'(bus.m_eof),  32'd0);
    chk("rst_frame", 32'(frame_cnt),  32'd0);
    chk("rst_ovf",   32'(ovf_err),    32'd0);
    chk("rst_afull", 32'(cw_afull),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h5A, 1'b0);
    chk("t1_vld",  32'(bus.m_vld),  32'd1);
    chk("t1_sof",  32'(bus.m_sof),  32'd1);
    chk("t1_data", 32'(bus.m_data), 32'h5A);
    do_clear();

    // 2: one full codeword, streaming
    npop = 0; nsof = 0; neof = 0;
    for (int i = 0; i < 128; i++) cyc(1'b1, 8'(i), 1'b1);
    drain();
    chk("t2_npop",  32'(npop),      32'd128);
    chk("t2_nsof",  32'(nsof),      32'd1);
    chk("t2_neof",  32'(neof),      32'd1);
    chk("t2_last",  32'(last_data), 32'h7F);
    chk("t2_frame", 32'(frame_cnt), 32'd1);

    // 3: overflow with output stalled, then framing realignment
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 10) chk("t3_afull11", 32'(cw_afull), 32'd0);
      if (i == 11) chk("t3_afull12", 32'(cw_afull), 32'd1);
    end
    chk("t3_ovf", 32'(ovf_err), 32'd1);
    npop = 0;
    drain();
    chk("t3_npop", 32'(npop),      32'd16);
    chk("t3_last", 32'(last_data), 32'h0F);
    chk("t3_ovf2", 32'(ovf_err),   32'd1);
    sof_80 = 1'b0;
    for (int i = 20; i <= 128; i++) cyc(1'b1, 8'(i), 1'b1);
    drain();
    chk("t3_sof129", 32'(sof_80),    32'd1);
    chk("t3_frame",  32'(frame_cnt), 32'd2);
    chk("t3_ovf3",   32'(ovf_err),   32'd1);
    do_clear();
    chk("t3_ovf_clr", 32'(ovf_err), 32'd0);

    // 4: full FIFO with write and pop together
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("t4_afull", 32'(cw_afull), 32'd1);
    chk("t4_ovf0",  32'(ovf_err),  32'd0);
    cyc(1'b1, 8'h99, 1'b1);
    chk("t4_ovf1",   32'(ovf_err),  32'd0);
    chk("t4_afull2", 32'(cw_afull), 32'd1);
    npop = 0;
    drain();
    chk("t4_npop", 32'(npop),      32'd16);
    chk("t4_last", 32'(last_data), 32'h99);
    do_clear();

    // 5: ready toggling every cycle over two codewords, encoder paced by cw_afull
    sent = 0;
    npop = 0;
    for (int k = 0; k < 3000 && (sent < 256 || q.size() != 0); k++) begin
      v = (sent < 256) && !cw_afull;
      cyc(v, 8'(sent), k[0]);
      if (v) sent++;
    end
    chk("t5_sent",  32'(sent),      32'd256);
    chk("t5_npop",  32'(npop),      32'd256);
    chk("t5_frame", 32'(frame_cnt), 32'd2);
    chk("t5_ovf",   32'(ovf_err),   32'd0);
    chk("t5_empty", 32'(bus.m_vld), 32'd0);
    do_clear();

    // 6: sync clear mid-codeword
    for (int i = 0; i <= 60; i++) cyc(1'b1, 8'(i), 1'b1);
    do_clear();
    chk("t6_vld",   32'(bus.m_vld), 32'd0);
    chk("t6_frame", 32'(frame_cnt), 32'd0);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("t6_sof",  32'(bus.m_sof),  32'd1);
    chk("t6_data", 32'(bus.m_data), 32'hAA);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
